// File: rtl/app_mult_pkg.sv
// Shared definitions for the approximate-multiplier scheduler.
// Holds the scheduler state encoding, the default sizing constants and
// the helper that sizes requester-index fields.
package app_mult_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } sched_state_t;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_TIMEOUT = 64;

    // Width of a requester index; never less than one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/app_mult_sched_rr_picker.sv
// Round-robin picker: combinational, finds the first set request bit at or
// after ptr, wrapping modulo NREQ.
// Ports:
//   req  - request vector
//   ptr  - index with highest priority this round
//   any  - at least one request is set
//   idx  - index of the chosen request (valid when any=1)
module rr_picker
    import app_mult_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    // The request vector is doubled so the wrap-around search becomes a
    // plain lowest-bit search over bits at or above ptr.
    logic [2*NREQ-1:0] dbl_req;
    assign dbl_req = {req, req};

    always_comb begin
        any = 1'b0;
        idx = '0;
        // Scan downwards so the lowest qualifying bit wins.
        for (int i = 2*NREQ-1; i >= 0; i--) begin
            if (dbl_req[i] && (i >= int'(ptr))) begin
                any = 1'b1;
                idx = IDW'(i % NREQ);
            end
        end
    end

endmodule

// File: rtl/app_mult_sched.sv
// Round-robin scheduler sharing one multiplier core among NREQ requesters.
// A requester's operands are latched, the core is started, and its product
// is returned tagged with the requester id. A watchdog aborts a transaction
// whose core never reports done.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req, a_in, b_in   - per-requester request level and packed operands
//   gnt               - one-hot pulse when a requester's operands are taken
//   mult_start/a/b    - start pulse and operands to the core
//   mult_done/res     - core completion and product
//   res_valid/res/res_id/res_err - result pulse, product, owner, timeout flag
//   busy              - scheduler not idle
module app_mult_sched
    import app_mult_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int IDW    = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  mult_start,
    output logic [WIDTH-1:0]      mult_a,
    output logic [WIDTH-1:0]      mult_b,
    input  logic                  mult_done,
    input  logic [2*WIDTH-1:0]    mult_res,
    output logic                  res_valid,
    output logic [2*WIDTH-1:0]    res,
    output logic [IDW-1:0]        res_id,
    output logic                  res_err,
    output logic                  busy
);

    localparam int WDW = $clog2(TIMEOUT);

    sched_state_t       state_q;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     id_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WDW-1:0]     wd_q;
    logic [2*WIDTH-1:0] res_q;
    logic [IDW-1:0]     res_id_q;
    logic               res_err_q;

    logic               pick_any;
    logic [IDW-1:0]     pick_idx;

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wd_q      <= '0;
            res_q     <= '0;
            res_id_q  <= '0;
            res_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        id_q    <= pick_idx;
                        a_q     <= a_in[pick_idx*WIDTH +: WIDTH];
                        b_q     <= b_in[pick_idx*WIDTH +: WIDTH];
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wd_q    <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    wd_q <= wd_q + 1'b1;
                    // Completion takes priority over a simultaneous timeout.
                    if (mult_done) begin
                        res_q     <= mult_res;
                        res_id_q  <= id_q;
                        res_err_q <= 1'b0;
                        state_q   <= RESP;
                    end else if (wd_q == WDW'(TIMEOUT-1)) begin
                        res_q     <= '0;
                        res_id_q  <= id_q;
                        res_err_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    ptr_q   <= (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes are decoded from state so they vanish the instant rst rises.
    assign gnt        = (state_q == LAUNCH) ? (NREQ'(1) << id_q) : '0;
    assign mult_start = (state_q == LAUNCH);
    assign res_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign mult_a     = a_q;
    assign mult_b     = b_q;
    assign res        = res_q;
    assign res_id     = res_id_q;
    assign res_err    = res_err_q;

endmodule
